// File: rtl/user_rom_streamer.sv
// rtl/user_rom_streamer.sv - OBI manager that streams the NUL-terminated user ROM string as bytes
package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_rom_streamer #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter logic [31:0]       BaseAddr  = 32'h0,
    parameter int unsigned       MaxWords  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [5:0] len_o,
    output obi_req_t   obi_req_o,
    input  obi_rsp_t   obi_rsp_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i
);

    localparam int unsigned DataWidth = ObiCfg.DataWidth;
    localparam logic [2:0]  LastWord  = 3'(MaxWords - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             word_idx_q, word_idx_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [5:0]             len_q, len_d;
    logic                   err_q, err_d;
    logic [DataWidth-1:0]   word_q, word_d;
    logic [7:0]             cur_byte;

    assign cur_byte = word_q[{byte_idx_q, 3'b000} +: 8];
    assign len_o    = len_q;
    assign err_o    = err_q;

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        len_d        = len_q;
        err_d        = err_q;
        word_d       = word_q;
        obi_req_o    = '0;
        byte_o       = 8'h00;
        byte_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = REQ;
                    word_idx_d = 3'd0;
                    byte_idx_d = 2'd0;
                    len_d      = 6'd0;
                    err_d      = 1'b0;
                end
            end
            REQ: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = BaseAddr + {27'd0, word_idx_q, 2'b00};
                obi_req_o.a.be   = '1;
                if (obi_rsp_i.gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses are only meaningful here; stale rvalid elsewhere is dropped.
                if (obi_rsp_i.rvalid) begin
                    word_d = obi_rsp_i.r.rdata;
                    if (obi_rsp_i.r.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        byte_idx_d = 2'd0;
                        state_d    = EMIT;
                    end
                end
            end
            EMIT: begin
                byte_o = cur_byte;
                if (cur_byte == 8'h00) begin
                    state_d = DONE;
                end else begin
                    byte_valid_o = 1'b1;
                    if (byte_ready_i) begin
                        len_d      = len_q + 6'd1;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            word_idx_d = word_idx_q + 3'd1;
                            state_d    = (word_idx_q == LastWord) ? DONE : REQ;
                        end
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            word_idx_q <= 3'd0;
            byte_idx_q <= 2'd0;
            len_q      <= 6'd0;
            err_q      <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            len_q      <= len_d;
            err_q      <= err_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: tb/tb_user_rom_streamer.sv
// tb/tb_user_rom_streamer.sv - table-driven bench for user_rom_streamer against a 2-cycle ROM model
module tb_user_rom_streamer;

    localparam logic [31:0] Base = 32'h0000_0100;
    localparam logic [7:0][31:0] MainRom = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                            32'h43495341, 32'h20732753, 32'h50264c4a};
    localparam logic [7:0][31:0] AllA    = {8{32'h41414141}};

    typedef struct {
        logic [7:0][31:0] w;
        int               err_word;
        bit               rand_ready;
        bit               busy_pulse;
        string            exp;
        int               exp_len;
        int               exp_err;
        int               exp_nreq;
        int               exp_done_lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, err;
    logic [5:0]        len;
    obi_pkg::obi_req_t obi_req;
    obi_pkg::obi_rsp_t obi_rsp;
    logic [7:0]        byte_d;
    logic              byte_valid;
    logic              byte_ready;

    logic [7:0][31:0]  rom;
    int                err_word;
    bit                rand_ready;
    logic              force_rv;
    logic              p1_v, p2_v;
    logic [2:0]        p1_i, p2_i;
    logic [31:0]       req_off;

    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    bit                mon_en = 0;
    logic [7:0]        q_bytes[$];
    logic [31:0]       q_addr[$];
    int                done_cnt, done_cyc, first_req_cyc, first_valid_cyc;
    bit                prev_stall;
    logic [7:0]        prev_byte;
    vec_t              vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    user_rom_streamer #(.BaseAddr(Base), .MaxWords(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .len_o       (len),
        .obi_req_o   (obi_req),
        .obi_rsp_i   (obi_rsp),
        .byte_o      (byte_d),
        .byte_valid_o(byte_valid),
        .byte_ready_i(byte_ready)
    );

    // ROM: grant in the request cycle, response two cycles later
    assign req_off = obi_req.a.addr - Base;
    always @(posedge clk) begin
        p1_v <= obi_req.req && obi_rsp.gnt;
        p1_i <= req_off[4:2];
        p2_v <= p1_v;
        p2_i <= p1_i;
    end

    always_comb begin
        obi_rsp          = '0;
        obi_rsp.gnt      = obi_req.req;
        obi_rsp.rvalid   = p2_v | force_rv;
        obi_rsp.r.rdata  = rom[p2_i];
        obi_rsp.r.err    = p2_v && (int'(p2_i) == err_word);
    end

    always @(posedge clk) begin
        #1;
        byte_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", int'(byte_valid), 1);
                check("stall_byte", int'(byte_d), int'(prev_byte));
            end
            if (byte_valid) begin
                check("no_nul", int'(byte_d != 8'h00), 1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (byte_ready) q_bytes.push_back(byte_d);
            end
            if (obi_req.req && obi_rsp.gnt) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                q_addr.push_back(obi_req.a.addr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_d;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        q_bytes.delete();
        q_addr.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    task automatic run_case(input int k);
        int    t0;
        bit    got;
        string s;
        rom        = vecs[k].w;
        err_word   = vecs[k].err_word;
        rand_ready = vecs[k].rand_ready;
        s          = vecs[k].exp;
        clear_mon();
        mon_en = 1;
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        check($sformatf("c%0d_busy", k), int'(busy), 1);
        if (vecs[k].busy_pulse) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check($sformatf("c%0d_done_seen", k), int'(got), 1);
        check($sformatf("c%0d_len", k), int'(len), vecs[k].exp_len);
        check($sformatf("c%0d_err", k), int'(err), vecs[k].exp_err);
        repeat (4) @(negedge clk);
        mon_en = 0;
        check($sformatf("c%0d_done_cnt", k), done_cnt, 1);
        check($sformatf("c%0d_len_hold", k), int'(len), vecs[k].exp_len);
        check($sformatf("c%0d_idle", k), int'(busy), 0);
        check($sformatf("c%0d_nbytes", k), q_bytes.size(), s.len());
        for (int i = 0; i < q_bytes.size() && i < s.len(); i++)
            check($sformatf("c%0d_byte%0d", k, i), int'(q_bytes[i]), int'(s[i]));
        check($sformatf("c%0d_nreq", k), q_addr.size(), vecs[k].exp_nreq);
        for (int i = 0; i < q_addr.size(); i++)
            check($sformatf("c%0d_addr%0d", k, i), int'(q_addr[i]), int'(Base + 32'(4 * i)));
        check($sformatf("c%0d_req_lat", k), first_req_cyc - t0, 1);
        if (vecs[k].exp_len > 0)
            check($sformatf("c%0d_byte_lat", k), first_valid_cyc - t0, 4);
        if (vecs[k].exp_done_lat >= 0)
            check($sformatf("c%0d_done_lat", k), done_cyc - t0, vecs[k].exp_done_lat);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{MainRom, -1, 0, 0, "JL&PS's ASIC", 12, 0, 4, -1};
        vecs[1] = '{MainRom, -1, 1, 0, "JL&PS's ASIC", 12, 0, 4, -1};
        vecs[2] = '{{224'h0, 32'h00000041}, -1, 0, 0, "A", 1, 0, 1, -1};
        vecs[3] = '{256'h0, -1, 0, 0, "", 0, 0, 1, 5};
        vecs[4] = '{AllA, -1, 0, 0, "AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA", 32, 0, 8, -1};
        vecs[5] = '{MainRom, 1, 0, 0, "JL&P", 4, 1, 2, -1};
        vecs[6] = '{MainRom, -1, 0, 0, "JL&PS's ASIC", 12, 0, 4, -1};
        vecs[7] = '{MainRom, -1, 1, 1, "JL&PS's ASIC", 12, 0, 4, -1};

        rom        = MainRom;
        err_word   = -1;
        rand_ready = 0;
        force_rv   = 1'b0;
        start      = 1'b0;
        rst        = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", int'(obi_req != '0), 0);
        check("rst_valid", int'(byte_valid), 0);
        check("rst_byte", int'(byte_d), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_len", int'(len), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_case(k);

        // Reset in the first EMIT cycle
        rom = MainRom; err_word = -1; rand_ready = 0;
        clear_mon();
        mon_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (byte_valid) seen = 1;
        end
        check("mid_emit_seen", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_req", int'(obi_req != '0), 0);
        check("mid_rst_valid", int'(byte_valid), 0);
        check("mid_rst_byte", int'(byte_d), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_len", int'(len), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_no_req", q_addr.size(), 1);
        @(posedge clk); #1 force_rv = 1'b1;
        @(posedge clk); #1 force_rv = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rv_busy", int'(busy), 0);
        check("late_rv_valid", int'(byte_valid), 0);
        check("late_rv_no_done", done_cnt, 0);
        mon_en = 0;

        run_case(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
